thumb_predecode: RTL and testbench

Parametrised Thumb/Thumb-2 pre-decode stage between instruction fetch and the main decoder. It accepts 32-bit fetch words and splits them into halfwords in a circular buffer. It reassembles 16-bit and 32-bit instructions that straddle word boundaries and tracks the instruction PC. Each instruction is presented with a registered one-hot class vector under a valid/ready handshake.

---
 rtl/thumb_predecode.sv | 176 +++++++++++++++++
 tb/tb_thumb_predecode.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_predecode.sv
`default_nettype none
// ============================================================================
//  Module      : thumb_predecode
//  Description : Thumb/Thumb-2 pre-decode stage. Splits 32-bit fetch words
//                into a circular halfword buffer, reassembles 16/32-bit
//                instructions, tracks the instruction PC and presents each
//                instruction with a registered one-hot class vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module thumb_predecode #(
    parameter int HW_DEPTH = 8,
    parameter int PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    input  logic            fetch_valid,
    input  logic [31:0]     fetch_data,
    output logic            fetch_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic            out_is32,
    output logic [PC_W-1:0] out_pc,
    output logic [12:0]     out_class
);

    localparam int c_ptr_w = $clog2(HW_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_two = c_ptr_w'(2);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_two = c_cnt_w'(2);
    localparam logic [c_cnt_w-1:0] c_cnt_lim = c_cnt_w'(HW_DEPTH - 2);
    localparam logic [PC_W-1:0]    c_pc_two  = PC_W'(2);
    localparam logic [PC_W-1:0]    c_pc_four = PC_W'(4);

    logic [15:0]        r_buf [HW_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [PC_W-1:0]    r_pc;
    logic               r_skip_hw;

    logic               r_out_valid;
    logic [31:0]        r_out_inst;
    logic               r_out_is32;
    logic [PC_W-1:0]    r_out_pc;
    logic [12:0]        r_out_class;

    logic [15:0]        w_hw0;
    logic [15:0]        w_hw1;
    logic               w_is32;
    logic               w_push;
    logic               w_load_en;
    logic               w_pop16;
    logic               w_pop32;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_push_n;
    logic [c_cnt_w-1:0] w_pop_n;
    logic [12:0]        w_class16;
    logic               w_unused_flush_pc0;

    // Restart addresses are halfword aligned; the LSB carries no meaning.
    assign w_unused_flush_pc0 = flush_pc[0];

    assign w_hw0  = r_buf[r_rd_ptr];
    assign w_hw1  = r_buf[r_rd_ptr + c_ptr_one];
    assign w_is32 = (w_hw0[15:11] == 5'b11101) ||
                    (w_hw0[15:11] == 5'b11110) ||
                    (w_hw0[15:11] == 5'b11111);

    // Room for a full word is judged on the registered count alone.
    assign fetch_ready = !rst && !flush && (r_count <= c_cnt_lim);
    assign w_push      = fetch_valid && fetch_ready;

    // A 32-bit head is only released once both halfwords are buffered.
    assign w_load_en = !r_out_valid || out_ready;
    assign w_pop16   = w_load_en && !w_is32 && (r_count >= c_cnt_one);
    assign w_pop32   = w_load_en &&  w_is32 && (r_count >= c_cnt_two);
    assign w_pop     = w_pop16 || w_pop32;

    assign w_push_n = !w_push ? '0 : (r_skip_hw ? c_cnt_one : c_cnt_two);
    assign w_pop_n  = w_pop32 ? c_cnt_two : (w_pop16 ? c_cnt_one : '0);

    // Class of a 16-bit encoding from its top six bits (exactly one bit set).
    always_comb begin
        w_class16 = '0;
        casez (w_hw0[15:10])
            6'b00????: w_class16[11] = 1'b1;
            6'b010000: w_class16[10] = 1'b1;
            6'b010001: w_class16[9]  = 1'b1;
            6'b01001?: w_class16[8]  = 1'b1;
            6'b0101??,
            6'b011???,
            6'b100???: w_class16[7]  = 1'b1;
            6'b10100?: w_class16[6]  = 1'b1;
            6'b10101?: w_class16[5]  = 1'b1;
            6'b1011??: w_class16[4]  = 1'b1;
            6'b11000?: w_class16[3]  = 1'b1;
            6'b11001?: w_class16[2]  = 1'b1;
            6'b1101??: w_class16[1]  = 1'b1;
            6'b11100?: w_class16[0]  = 1'b1;
            default:   w_class16     = '0;
        endcase
    end

    // Halfword storage; lower-address halfword goes in first.
    always_ff @(posedge clk) begin
        if (w_push) begin
            if (r_skip_hw) begin
                r_buf[r_wr_ptr] <= fetch_data[31:16];
            end else begin
                r_buf[r_wr_ptr]             <= fetch_data[15:0];
                r_buf[r_wr_ptr + c_ptr_one] <= fetch_data[31:16];
            end
        end
    end

    // Pointers, occupancy, PC tracking and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pc        <= '0;
            r_skip_hw   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_is32  <= 1'b0;
            r_out_pc    <= '0;
            r_out_class <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pc        <= {flush_pc[PC_W-1:1], 1'b0};
            r_skip_hw   <= flush_pc[1];
            r_out_valid <= 1'b0;
        end else begin
            r_count <= r_count + w_push_n - w_pop_n;
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + (r_skip_hw ? c_ptr_one : c_ptr_two);
                r_skip_hw <= 1'b0;
            end
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_pc    <= r_pc;
                r_out_is32  <= w_is32;
                if (w_is32) begin
                    r_rd_ptr    <= r_rd_ptr + c_ptr_two;
                    r_pc        <= r_pc + c_pc_four;
                    r_out_inst  <= {w_hw0, w_hw1};
                    r_out_class <= 13'h1000;
                end else begin
                    r_rd_ptr    <= r_rd_ptr + c_ptr_one;
                    r_pc        <= r_pc + c_pc_two;
                    r_out_inst  <= {16'h0000, w_hw0};
                    r_out_class <= w_class16;
                end
            end else if (w_load_en) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_is32  = r_out_is32;
    assign out_pc    = r_out_pc;
    assign out_class = r_out_class;

endmodule
`default_nettype wire

// File: tb/tb_thumb_predecode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_thumb_predecode
//  Description : Self-checking bench for thumb_predecode; a halfword-stream
//                model predicts the emitted instructions into a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_thumb_predecode;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_is32;
    logic [31:0] out_pc;
    logic [12:0] out_class;

    thumb_predecode #(.HW_DEPTH(8), .PC_W(32)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_is32(out_is32), .out_pc(out_pc), .out_class(out_class)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic        is32;
        logic [31:0] pc;
        logic [12:0] cls;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    logic [15:0] mq[$];
    logic [31:0] m_pc   = 0;
    logic        m_skip = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] ref_class(input logic [15:0] hw);
        int t;
        int k;
        t = int'(hw[15:10]);
        if      (t < 16) k = 11;
        else if (t == 16) k = 10;
        else if (t == 17) k = 9;
        else if (t < 20) k = 8;
        else if (t < 40) k = 7;
        else if (t < 42) k = 6;
        else if (t < 44) k = 5;
        else if (t < 48) k = 4;
        else if (t < 50) k = 3;
        else if (t < 52) k = 2;
        else if (t < 56) k = 1;
        else if (t < 58) k = 0;
        else             k = 12;
        return 13'(1) << k;
    endfunction

    // Turn buffered model halfwords into complete expected instructions.
    task automatic model_push(input logic [31:0] w);
        exp_t e;
        if (m_skip) begin
            mq.push_back(w[31:16]);
            m_skip = 1'b0;
        end else begin
            mq.push_back(w[15:0]);
            mq.push_back(w[31:16]);
        end
        while (mq.size() > 0) begin
            if (int'(mq[0][15:10]) >= 58) begin
                if (mq.size() < 2) break;
                e.inst = {mq[0], mq[1]};
                e.is32 = 1'b1;
                e.pc   = m_pc;
                e.cls  = 13'h1000;
                void'(mq.pop_front());
                void'(mq.pop_front());
                m_pc = m_pc + 4;
            end else begin
                e.inst = {16'h0000, mq[0]};
                e.is32 = 1'b0;
                e.pc   = m_pc;
                e.cls  = ref_class(mq[0]);
                void'(mq.pop_front());
                m_pc = m_pc + 2;
            end
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_word(input logic [31:0] w);
        int   n;
        logic ok;
        n = 0;
        ok = 1'b0;
        fetch_valid = 1'b1;
        fetch_data  = w;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (fetch_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) chk("push_accept", 96'(ok), 96'(1));
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        if (ok) model_push(w);
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        mq.delete();
        exp_q.delete();
        m_pc   = {pc[31:1], 1'b0};
        m_skip = pc[1];
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 96'(exp_q.size()), 96'(0));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor and hold-stability check, sampled mid-cycle.
    logic [78:0] snap;
    logic        prev_hold = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !flush) begin
            if (prev_hold)
                chk("hold_stable", 96'({out_valid, out_inst, out_is32, out_pc, out_class}), 96'(snap));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 96'(out_inst), 96'hFFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_inst", 96'(out_inst), 96'(e.inst));
                    chk("out_is32", 96'(out_is32), 96'(e.is32));
                    chk("out_pc", 96'(out_pc), 96'(e.pc));
                    chk("out_class", 96'(out_class), 96'(e.cls));
                    chk("class_onehot", 96'($onehot(out_class)), 96'(1));
                end
            end
        end
        prev_hold = !rst && !flush && out_valid && !out_ready;
        snap      = {out_valid, out_inst, out_is32, out_pc, out_class};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [5:0]  v6;
        rst = 1'b1; flush = 1'b0; flush_pc = '0;
        fetch_valid = 1'b0; fetch_data = '0; out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_out_inst", 96'(out_inst), 96'(0));
        chk("rst_out_is32", 96'(out_is32), 96'(0));
        chk("rst_out_pc", 96'(out_pc), 96'(0));
        chk("rst_out_class", 96'(out_class), 96'(0));
        chk("rst_fetch_ready", 96'(fetch_ready), 96'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fetch_ready", 96'(fetch_ready), 96'(1));
        @(posedge clk);
        #1;

        // Two 16-bit instructions in one word, with latency check
        out_ready = 1'b1;
        push_word(32'h4408_2001);
        chk("lat_not_yet", 96'(out_valid), 96'(0));
        @(posedge clk);
        #1;
        chk("lat_first", 96'({out_valid, out_inst}), 96'({1'b1, 32'h0000_2001}));
        drain();

        // Flush to an odd halfword: only the upper half is used
        do_flush(32'h0000_0102);
        push_word(32'hE7FE_BF00);
        drain();
        chk("skip_no_more", 96'(out_valid), 96'(0));

        // 32-bit instruction straddling two words
        do_flush(32'h0);
        push_word(32'hF000_2000);
        push_word(32'h0000_F800);
        chk("split_first", 96'(out_inst), 96'(32'h0000_2000));
        @(posedge clk);
        #1;
        chk("split_32", 96'({out_valid, out_is32, out_inst}), 96'({2'b11, 32'hF000_F800}));
        drain();

        // Backpressure with continuous pushing across the pointer wrap
        do_flush(32'h0000_1000);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    r = $urandom();
                    push_word(r);
                end
            end
            begin
                repeat (30) @(posedge clk);
                @(negedge clk);
                chk("stall_fetch_ready", 96'(fetch_ready), 96'(0));
                chk("stall_out_valid", 96'(out_valid), 96'(1));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush together with a fetch word while an output is pending
        do_flush(32'h0);
        out_ready = 1'b0;
        push_word(32'h1234_0001);
        @(posedge clk);
        #1;
        chk("pend_valid", 96'(out_valid), 96'(1));
        fetch_valid = 1'b1;
        fetch_data  = 32'h4408_2001;
        do_flush(32'h0000_0200);
        fetch_valid = 1'b0;
        chk("flush_clears_valid", 96'(out_valid), 96'(0));
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_word_dropped", 96'(out_valid), 96'(0));
        push_word(32'h2003_2002);
        drain();

        // Sweep every top-six-bit pattern of the head halfword
        do_flush(32'h0);
        for (int v = 0; v < 64; v++) begin
            r  = $urandom();
            v6 = 6'(v);
            push_word({r[15:0], v6, r[25:16]});
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
